// File: rtl/hazard_pkg.sv
// Shared definitions for the RAW-hazard scoreboard and its instruction decoder.
package hazard_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_SW       = 6'b101011;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [2:0] OP_IALU_PFX = 3'b001;

    // MIPS register specifiers are 5 bits wide.
    localparam int unsigned SB_REG_AW = 5;

    // Forwarding select value meaning "read the register file".
    localparam int unsigned FWD_RF = 0;

    typedef struct packed {
        logic                 valid;
        logic [SB_REG_AW-1:0] dest;
        logic                 is_load;
    } sb_entry_t;

endpackage

// File: rtl/mips_reg_decode.sv
// Combinational register-usage decoder: which sources an instruction reads,
// which register it writes, and whether it is a load. Register $0 is never
// reported as a source or destination.
module mips_reg_decode
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [31:0]       instr_i,
    output logic              rs_used_o,
    output logic [REG_AW-1:0] rs_o,
    output logic              rt_used_o,
    output logic [REG_AW-1:0] rt_o,
    output logic              dest_valid_o,
    output logic [REG_AW-1:0] dest_o,
    output logic              is_load_o
);

    logic [5:0]        op;
    logic [REG_AW-1:0] rd;
    logic              rs_src;
    logic              rt_src;
    logic              has_dest;
    logic              dest_is_rd;
    logic              load;
    logic              unused_low;

    assign op         = instr_i[31:26];
    assign rs_o       = REG_AW'(instr_i[25:21]);
    assign rt_o       = REG_AW'(instr_i[20:16]);
    assign rd         = REG_AW'(instr_i[15:11]);
    assign unused_low = ^instr_i[10:0];

    // Classify the opcode into source/destination usage.
    always_comb begin
        rs_src     = 1'b0;
        rt_src     = 1'b0;
        has_dest   = 1'b0;
        dest_is_rd = 1'b0;
        load       = 1'b0;
        case (op)
            OP_RTYPE: begin
                rs_src     = 1'b1;
                rt_src     = 1'b1;
                has_dest   = 1'b1;
                dest_is_rd = 1'b1;
            end
            OP_LW: begin
                rs_src   = 1'b1;
                has_dest = 1'b1;
                load     = 1'b1;
            end
            OP_SW, OP_BEQ: begin
                rs_src = 1'b1;
                rt_src = 1'b1;
            end
            default: begin
                if (op[5:3] == OP_IALU_PFX) begin
                    rs_src   = 1'b1;
                    has_dest = 1'b1;
                end
            end
        endcase
    end

    assign dest_o       = dest_is_rd ? rd : rt_o;
    assign rs_used_o    = rs_src && (rs_o != '0);
    assign rt_used_o    = rt_src && (rt_o != '0);
    assign dest_valid_o = has_dest && (dest_o != '0);
    assign is_load_o    = load;

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW-hazard and forwarding unit: tracks destination tags of the DEPTH
// instructions downstream of Decode and, for the Decode instruction, picks the
// nearest producer per source and requests a stall on an unready load.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned SEL_W      = $clog2(DEPTH + 1),
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_d,
    input  logic             valid_d,
    input  logic             advance,
    input  logic             flush_d,
    output logic [SEL_W-1:0] fwd_sel_rs,
    output logic [SEL_W-1:0] fwd_sel_rt,
    output logic             stall_d,
    output logic [CNT_W-1:0] stall_cnt
);

    logic              rs_used, rt_used, dest_valid, is_load;
    logic [REG_AW-1:0] rs, rt, dest;

    sb_entry_t         entries_q [1:DEPTH];
    sb_entry_t         entries_d [1:DEPTH];
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [DEPTH:1]    rs_hit, rt_hit, ld_early;
    logic [SEL_W-1:0]  rs_sel, rt_sel;
    logic              rs_ld, rt_ld;
    logic              stall_c;

    mips_reg_decode #(
        .REG_AW (REG_AW)
    ) u_decode (
        .instr_i      (instr_d),
        .rs_used_o    (rs_used),
        .rs_o         (rs),
        .rt_used_o    (rt_used),
        .rt_o         (rt),
        .dest_valid_o (dest_valid),
        .dest_o       (dest),
        .is_load_o    (is_load)
    );

    // Per-stage tag compare; ld_early marks loads whose data is not yet forwardable.
    for (genvar k = 1; k <= DEPTH; k++) begin : g_match
        assign rs_hit[k]   = entries_q[k].valid && (entries_q[k].dest == rs);
        assign rt_hit[k]   = entries_q[k].valid && (entries_q[k].dest == rt);
        assign ld_early[k] = entries_q[k].is_load && (k < int'(LOAD_READY));
    end

    // Nearest-producer priority: scan oldest to youngest so the smallest distance wins.
    always_comb begin
        rs_sel = SEL_W'(FWD_RF);
        rt_sel = SEL_W'(FWD_RF);
        rs_ld  = 1'b0;
        rt_ld  = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rs_hit[DEPTH - i]) begin
                rs_sel = SEL_W'(DEPTH - i);
                rs_ld  = ld_early[DEPTH - i];
            end
            if (rt_hit[DEPTH - i]) begin
                rt_sel = SEL_W'(DEPTH - i);
                rt_ld  = ld_early[DEPTH - i];
            end
        end
    end

    assign stall_c    = valid_d && !flush_d && ((rs_used && rs_ld) || (rt_used && rt_ld));
    assign stall_d    = stall_c;
    assign fwd_sel_rs = (valid_d && !stall_c && rs_used) ? rs_sel : SEL_W'(FWD_RF);
    assign fwd_sel_rt = (valid_d && !stall_c && rt_used) ? rt_sel : SEL_W'(FWD_RF);
    assign stall_cnt  = stall_cnt_q;

    // Next state: shift the tag pipeline and count stalled cycles when advancing.
    always_comb begin
        entries_d   = entries_q;
        stall_cnt_d = stall_cnt_q;
        if (advance) begin
            for (int unsigned k = DEPTH; k >= 2; k--) begin
                entries_d[k] = entries_q[k-1];
            end
            entries_d[1].valid   = valid_d && !flush_d && !stall_c && dest_valid;
            entries_d[1].dest    = SB_REG_AW'(dest);
            entries_d[1].is_load = is_load;
            if (stall_c && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                entries_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            entries_q   <= entries_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench for hazard_scoreboard (DEPTH=3, LOAD_READY=2).
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_d = '0;
    logic        valid_d = 1'b0;
    logic        advance = 1'b0;
    logic        flush_d = 1'b0;
    logic [1:0]  fwd_sel_rs, fwd_sel_rt;
    logic        stall_d;
    logic [15:0] stall_cnt;

    typedef struct {
        string       name;
        logic [1:0]  rs;
        logic [1:0]  rt;
        logic        st;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q [$];
    int   n_total = 0;
    int   n_pass  = 0;

    hazard_scoreboard #(
        .REG_AW     (5),
        .DEPTH      (3),
        .LOAD_READY (2),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_d    (instr_d),
        .valid_d    (valid_d),
        .advance    (advance),
        .flush_d    (flush_d),
        .fwd_sel_rs (fwd_sel_rs),
        .fwd_sel_rt (fwd_sel_rt),
        .stall_d    (stall_d),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Drive one Decode cycle and queue the outputs expected during it.
    task automatic step(input string name, input logic rst, input logic [31:0] ins,
                        input logic vld, input logic adv, input logic fl,
                        input logic [1:0] ers, input logic [1:0] ert,
                        input logic est, input logic [15:0] ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n   = rst;
        instr_d = ins;
        valid_d = vld;
        advance = adv;
        flush_d = fl;
        e.name = name; e.rs = ers; e.rt = ert; e.st = est; e.cnt = ecnt;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_total++;
                if (fwd_sel_rs === e.rs && fwd_sel_rt === e.rt && stall_d === e.st && stall_cnt === e.cnt) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got rs=%0d rt=%0d stall=%0b cnt=%0d, expected rs=%0d rt=%0d stall=%0b cnt=%0d",
                             e.name, fwd_sel_rs, fwd_sel_rt, stall_d, stall_cnt, e.rs, e.rt, e.st, e.cnt);
                end
            end
        end
    end

    initial begin
        int guard;
        // reset held
        step("reset",        1'b0, r_add(3, 1, 2),                 1, 1, 0, 0, 0, 0, 0);
        // back-to-back dependency
        step("b2b_prod",     1'b1, r_add(3, 1, 2),                 1, 1, 0, 0, 0, 0, 0);
        step("b2b_cons",     1'b1, r_add(4, 3, 5),                 1, 1, 0, 1, 0, 0, 0);
        // load-use
        step("lu_load",      1'b1, i_op(6'b100011, 1, 7, 16'd0),   1, 1, 0, 0, 0, 0, 0);
        step("lu_stall",     1'b1, r_add(8, 7, 7),                 1, 1, 0, 0, 0, 1, 0);
        step("lu_fwd2",      1'b1, r_add(8, 7, 7),                 1, 1, 0, 2, 2, 0, 1);
        // nearest producer wins
        step("nw_add",       1'b1, r_add(3, 1, 2),                 1, 1, 0, 0, 0, 0, 1);
        step("nw_gap",       1'b1, r_add(10, 11, 12),              1, 1, 0, 0, 0, 0, 1);
        step("nw_addi",      1'b1, i_op(6'b001000, 0, 3, 16'd5),   1, 1, 0, 0, 0, 0, 1);
        step("nw_beq",       1'b1, i_op(6'b000100, 3, 0, 16'd4),   1, 1, 0, 1, 0, 0, 1);
        // distance DEPTH reach
        step("reach_prod",   1'b1, r_add(9, 1, 2),                 1, 1, 0, 0, 0, 0, 1);
        step("reach_gap1",   1'b1, r_add(13, 14, 15),              1, 1, 0, 0, 0, 0, 1);
        step("reach_gap2",   1'b1, r_add(16, 17, 18),              1, 1, 0, 0, 0, 0, 1);
        step("reach_sw",     1'b1, i_op(6'b101011, 9, 9, 16'd0),   1, 1, 0, 3, 3, 0, 1);
        // expiry beyond DEPTH
        step("exp_prod",     1'b1, r_add(9, 1, 2),                 1, 1, 0, 0, 0, 0, 1);
        step("exp_gap1",     1'b1, r_add(13, 14, 15),              1, 1, 0, 0, 0, 0, 1);
        step("exp_gap2",     1'b1, r_add(16, 17, 18),              1, 1, 0, 0, 0, 0, 1);
        step("exp_gap3",     1'b1, r_add(19, 20, 21),              1, 1, 0, 0, 0, 0, 1);
        step("exp_cons",     1'b1, r_add(22, 9, 9),                1, 1, 0, 0, 0, 0, 1);
        // freeze for 4 cycles
        step("frz_prod",     1'b1, r_add(5, 1, 2),                 1, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step("frz_hold",  1'b1, r_add(6, 5, 22),               1, 0, 0, 1, 2, 0, 1);
        end
        step("frz_resume",   1'b1, r_add(6, 5, 22),                1, 1, 0, 1, 2, 0, 1);
        // flushed load leaves no tag behind
        step("fl_load",      1'b1, i_op(6'b100011, 1, 7, 16'd0),   1, 1, 1, 0, 0, 0, 1);
        step("fl_cons",      1'b1, r_add(8, 7, 7),                 1, 1, 0, 0, 0, 0, 1);
        // flush overrides a stall condition
        step("fs_load",      1'b1, i_op(6'b100011, 1, 7, 16'd0),   1, 1, 0, 0, 0, 0, 1);
        step("fs_flush",     1'b1, r_add(8, 7, 7),                 1, 1, 1, 1, 1, 0, 1);
        // stall while frozen does not count
        step("sf_load",      1'b1, i_op(6'b100011, 1, 7, 16'd0),   1, 1, 0, 0, 0, 0, 1);
        step("sf_frozen",    1'b1, r_add(8, 7, 0),                 1, 0, 0, 0, 0, 1, 1);
        step("sf_adv",       1'b1, r_add(8, 7, 0),                 1, 1, 0, 0, 0, 1, 1);
        step("sf_after",     1'b1, r_add(8, 7, 0),                 1, 1, 0, 2, 0, 0, 2);
        // asynchronous reset mid-stream
        step("rst_async",    1'b0, r_add(1, 8, 7),                 1, 1, 0, 0, 0, 0, 0);
        step("rst_release",  1'b1, r_add(1, 8, 7),                 1, 1, 0, 0, 0, 0, 0);
        // invalid Decode slot: no forward, no tag inserted
        step("inv_slot",     1'b1, r_add(2, 1, 1),                 0, 1, 0, 0, 0, 0, 0);
        step("post_inv",     1'b1, r_add(2, 1, 1),                 1, 1, 0, 2, 2, 0, 0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
